// File: rtl/uart_cmd_decoder_if.sv
// Byte handshake between the UART receiver/transmitter pair and the command decoder.
// The UART side is the master; the decoder consumes received bytes and requests acks.
interface uart_cmd_decoder_if;
    logic [7:0] rxd_data;
    logic       rxd_flag;
    logic       txd_flag;
    logic       txd_en;
    logic [7:0] txd_data;

    modport master (
        output rxd_data,
        output rxd_flag,
        output txd_flag,
        input  txd_en,
        input  txd_data
    );

    modport slave (
        input  rxd_data,
        input  rxd_flag,
        input  txd_flag,
        output txd_en,
        output txd_data
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Decodes ASCII command bytes into fixed-length button presses and returns a one-byte
// acknowledge (the command itself, or '?' for unknown bytes) to the UART transmitter.
module uart_cmd_decoder #(
    parameter int HOLD_CYCLES = 2_000_000,
    parameter bit ACK_ENABLE  = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    uart_cmd_decoder_if.slave bus,
    output logic              o_bt_w,
    output logic              o_bt_s,
    output logic              o_bt_a,
    output logic              o_bt_d,
    output logic              o_bt_st,
    output logic [15:0]       o_led,
    output logic [7:0]        o_err_cnt
);

    localparam int          NUM_BT  = 5;
    localparam logic [23:0] HOLD    = 24'(HOLD_CYCLES);
    localparam logic [7:0]  ACK_BAD = 8'h3F;

    typedef enum logic [1:0] {
        ACK_IDLE,
        ACK_SEND,
        ACK_WAIT
    } ackState_t;

    logic [NUM_BT-1:0] w_hit;
    logic              w_valid;
    logic [23:0]       r_cnt     [NUM_BT];
    logic [23:0]       w_cntNext [NUM_BT];
    logic [NUM_BT-1:0] r_bt;
    logic [7:0]        r_lastCmd;
    logic [7:0]        r_errCnt;
    logic [7:0]        r_pendData;
    logic              r_pendV;
    logic [7:0]        r_txdData;
    ackState_t         r_state;
    ackState_t         w_stateNext;
    logic              w_txdEn;
    logic              w_ackLoad;

    // Button index order: 0=W, 1=S, 2=A, 3=D, 4=ST
    always_comb begin
        w_hit = '0;
        case (bus.rxd_data)
            8'h41:        w_hit[0] = 1'b1;
            8'h42:        w_hit[1] = 1'b1;
            8'h43:        w_hit[2] = 1'b1;
            8'h44:        w_hit[3] = 1'b1;
            8'h46, 8'h4E: w_hit[4] = 1'b1;
            default:      w_hit    = '0;
        endcase
        w_valid = |w_hit;
    end

    always_comb begin
        for (int i = 0; i < NUM_BT; i++) begin
            w_cntNext[i] = r_cnt[i];
            if (bus.rxd_flag && w_hit[i]) begin
                w_cntNext[i] = HOLD;
            end else if (r_cnt[i] != '0) begin
                w_cntNext[i] = r_cnt[i] - 24'd1;
            end
        end
    end

    // Registering (next count != 0) makes the button rise the cycle after the byte
    // and stay high for exactly HOLD_CYCLES cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_BT; i++) begin
                r_cnt[i] <= '0;
            end
            r_bt <= '0;
        end else begin
            for (int i = 0; i < NUM_BT; i++) begin
                r_cnt[i] <= w_cntNext[i];
                r_bt[i]  <= (w_cntNext[i] != '0);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lastCmd <= '0;
            r_errCnt  <= '0;
        end else if (bus.rxd_flag) begin
            if (w_valid) begin
                r_lastCmd <= bus.rxd_data;
            end else if (r_errCnt != 8'hFF) begin
                r_errCnt <= r_errCnt + 8'd1;
            end
        end
    end

    // A new byte wins over the FSM consuming the entry, so the newest ack is never lost.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pendData <= '0;
            r_pendV    <= 1'b0;
        end else if (bus.rxd_flag) begin
            r_pendData <= w_valid ? bus.rxd_data : ACK_BAD;
            r_pendV    <= 1'b1;
        end else if (w_ackLoad) begin
            r_pendV <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ACK_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_txdEn     = 1'b0;
        w_ackLoad   = 1'b0;
        case (r_state)
            ACK_IDLE: begin
                if (ACK_ENABLE && r_pendV) begin
                    w_ackLoad   = 1'b1;
                    w_stateNext = ACK_SEND;
                end
            end
            ACK_SEND: begin
                w_txdEn     = 1'b1;
                w_stateNext = ACK_WAIT;
            end
            ACK_WAIT: begin
                if (bus.txd_flag) begin
                    w_stateNext = ACK_IDLE;
                end
            end
            default: w_stateNext = ACK_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_txdData <= '0;
        end else if (w_ackLoad) begin
            r_txdData <= r_pendData;
        end
    end

    assign bus.txd_en   = w_txdEn;
    assign bus.txd_data = r_txdData;

    assign o_bt_w    = r_bt[0];
    assign o_bt_s    = r_bt[1];
    assign o_bt_a    = r_bt[2];
    assign o_bt_d    = r_bt[3];
    assign o_bt_st   = r_bt[4];
    assign o_led     = {r_bt[0], r_bt[1], r_bt[2], r_bt[3], r_bt[4], 3'b000, r_lastCmd};
    assign o_err_cnt = r_errCnt;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: button windows and ack bytes are predicted from the stimulus;
// a second instance with a one-cycle hold and acks disabled runs alongside.
module tb_uart_cmd_decoder;

    localparam int HOLD = 100;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_cmd_decoder_if bus ();
    uart_cmd_decoder_if bus1 ();

    logic        bt_w, bt_s, bt_a, bt_d, bt_st;
    logic [15:0] led;
    logic [7:0]  err_cnt;
    logic        bt1_w, bt1_s, bt1_a, bt1_d, bt1_st;
    logic [15:0] led1;
    logic [7:0]  err1;

    assign bus1.rxd_data = bus.rxd_data;
    assign bus1.rxd_flag = bus.rxd_flag;
    assign bus1.txd_flag = 1'b0;

    uart_cmd_decoder #(.HOLD_CYCLES(HOLD), .ACK_ENABLE(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus),
        .o_bt_w(bt_w), .o_bt_s(bt_s), .o_bt_a(bt_a), .o_bt_d(bt_d), .o_bt_st(bt_st),
        .o_led(led), .o_err_cnt(err_cnt)
    );

    uart_cmd_decoder #(.HOLD_CYCLES(1), .ACK_ENABLE(1'b0)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus1),
        .o_bt_w(bt1_w), .o_bt_s(bt1_s), .o_bt_a(bt1_a), .o_bt_d(bt1_d), .o_bt_st(bt1_st),
        .o_led(led1), .o_err_cnt(err1)
    );

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    int         hStart [5];
    int         hEnd   [5];
    int         h1Start[5];
    int         h1End  [5];
    logic [7:0] expLed;
    int         expErr;
    logic [7:0] ackQ[$];
    int         txDelay       = 3;
    int         resetCount    = 0;
    int         lastEnCycle   = -1;
    int         lastFlagCycle = -1;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cycle);
        end
    endtask

    function automatic int buttonOf(input logic [7:0] b);
        case (b)
            8'h41:        return 0;
            8'h42:        return 1;
            8'h43:        return 2;
            8'h44:        return 3;
            8'h46, 8'h4E: return 4;
            default:      return -1;
        endcase
    endfunction

    task automatic clearModel();
        for (int i = 0; i < 5; i++) begin
            hStart[i]  = 0;
            hEnd[i]    = -1;
            h1Start[i] = 0;
            h1End[i]   = -1;
        end
        expLed = 8'h00;
        expErr = 0;
        ackQ.delete();
    endtask

    // One received byte at cycle N (next falling edge); returns mid-cycle N+1.
    task automatic applyStimulus(input logic [7:0] b, input bit expectAck);
        int bi;
        @(negedge clk);
        bus.rxd_data = b;
        bus.rxd_flag = 1'b1;
        bi = buttonOf(b);
        if (bi >= 0) begin
            if (cycle > hEnd[bi]) hStart[bi] = cycle + 1;
            hEnd[bi]    = cycle + HOLD;
            h1Start[bi] = cycle + 1;
            h1End[bi]   = cycle + 1;
            expLed      = b;
        end else if (expErr < 255) begin
            expErr++;
        end
        if (expectAck) ackQ.push_back(bi >= 0 ? b : 8'h3F);
        @(negedge clk);
        bus.rxd_flag = 1'b0;
        bus.rxd_data = 8'h41;
        checkOutput("led_cmd", {24'd0, led[7:0]}, {24'd0, expLed});
        checkOutput("err_cnt", {24'd0, err_cnt}, expErr);
    endtask

    // Per-cycle button windows plus the ack scoreboard.
    always @(negedge clk) begin
        logic [4:0] e;
        logic [4:0] e1;
        if (rst_n) begin
            for (int i = 0; i < 5; i++) begin
                e[4-i]  = (hStart[i] <= cycle) && (cycle <= hEnd[i]);
                e1[4-i] = (h1Start[i] <= cycle) && (cycle <= h1End[i]);
            end
            checkOutput("buttons", {bt_w, bt_s, bt_a, bt_d, bt_st}, e);
            checkOutput("led_hi", led[15:8], {e, 3'b000});
            checkOutput("hold1_bt", {bt1_w, bt1_s, bt1_a, bt1_d, bt1_st}, e1);
            checkOutput("noack_en", bus1.txd_en, 0);
            if (bus.txd_en) begin
                lastEnCycle = cycle;
                if (ackQ.size() == 0) checkOutput("ack_extra", bus.txd_en, 0);
                else                  checkOutput("ack_data", bus.txd_data, ackQ.pop_front());
            end
        end
    end

    // Transmitter model: answers each request with txd_flag after txDelay cycles.
    initial begin
        logic [7:0] held;
        int         rc;
        bus.txd_flag = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.txd_en) begin
                held = bus.txd_data;
                rc   = resetCount;
                repeat (txDelay) @(negedge clk);
                if (rc == resetCount) checkOutput("ack_hold", bus.txd_data, held);
                bus.txd_flag  = 1'b1;
                lastFlagCycle = cycle;
                @(negedge clk);
                bus.txd_flag = 1'b0;
            end
        end
    end

    initial begin
        bus.rxd_data = 8'h00;
        bus.rxd_flag = 1'b0;
        clearModel();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_bt", {bt_w, bt_s, bt_a, bt_d, bt_st}, 0);
        checkOutput("rst_led", led, 0);
        checkOutput("rst_err", err_cnt, 0);
        checkOutput("rst_txd_en", bus.txd_en, 0);
        checkOutput("rst_txd_data", bus.txd_data, 0);
        rst_n = 1'b1;

        // Single press and ack latency
        applyStimulus(8'h41, 1'b1);
        checkOutput("txd_en_n1", bus.txd_en, 0);
        @(negedge clk);
        checkOutput("txd_en_n2", bus.txd_en, 1);
        checkOutput("txd_data_n2", bus.txd_data, 8'h41);
        repeat (110) @(negedge clk);

        // Retrigger 50 cycles in
        applyStimulus(8'h42, 1'b1);
        repeat (48) @(negedge clk);
        applyStimulus(8'h42, 1'b1);
        repeat (110) @(negedge clk);

        // Overlapping independent buttons, both ST codes
        applyStimulus(8'h4E, 1'b1);
        repeat (8) @(negedge clk);
        applyStimulus(8'h43, 1'b1);
        repeat (110) @(negedge clk);
        applyStimulus(8'h46, 1'b1);
        repeat (110) @(negedge clk);

        // New byte coinciding with txd_flag in WAIT; next request two cycles after the flag
        txDelay = 20;
        applyStimulus(8'h44, 1'b1);
        repeat (2) @(negedge clk);
        applyStimulus(8'h41, 1'b0);
        repeat (16) @(negedge clk);
        applyStimulus(8'h43, 1'b1);
        repeat (10) @(negedge clk);
        checkOutput("turnaround", lastEnCycle - lastFlagCycle, 2);
        repeat (40) @(negedge clk);

        // Invalid bytes saturate the error counter
        txDelay = 3;
        for (int k = 0; k < 300; k++) begin
            applyStimulus(8'h5A, 1'b1);
            repeat (8) @(negedge clk);
        end
        repeat (20) @(negedge clk);

        // Several bytes while waiting on a slow transmitter: only the newest is acked
        txDelay = 1000;
        applyStimulus(8'h44, 1'b1);
        repeat (3) @(negedge clk);
        applyStimulus(8'h41, 1'b0);
        applyStimulus(8'h42, 1'b0);
        applyStimulus(8'h43, 1'b1);
        txDelay = 3;
        repeat (1100) @(negedge clk);
        checkOutput("coalesce_left", ackQ.size(), 0);

        // Reset while a button is held and the ack FSM is waiting
        txDelay = 50;
        applyStimulus(8'h44, 1'b1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        resetCount++;
        #1;
        checkOutput("mid_rst_bt", {bt_w, bt_s, bt_a, bt_d, bt_st}, 0);
        checkOutput("mid_rst_led", led, 0);
        checkOutput("mid_rst_err", err_cnt, 0);
        checkOutput("mid_rst_txd_en", bus.txd_en, 0);
        checkOutput("mid_rst_txd_data", bus.txd_data, 0);
        clearModel();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        txDelay = 3;
        applyStimulus(8'h42, 1'b1);
        repeat (120) @(negedge clk);

        checkOutput("ackq_left", ackQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Command decoder between the UART receiver and the game logic. Consumes the receiver's byte stream (`rxd_data`/`rxd_flag`) and decodes ASCII command bytes into per-button hold pulses of programmable length. Returns a one-byte acknowledge to the UART transmitter through its `txd_en`/`txd_data`/`txd_flag` handshake. Removes the "last byte stays asserted forever" behaviour of level decoding: each command gives a bounded press.

## Interface
- `HOLD_CYCLES`, 2_000_000 — press length in `clk` cycles (20 ms at 100 MHz); legal range 1..2^24-1.
- `ACK_ENABLE`, 1 — 1: send acknowledge bytes; 0: `txd_en` is tied low and the ack FSM stays in IDLE.

- `clk`  in  1  system clock, 100 MHz
- `rst_n`  in  1  asynchronous, active-low reset
- `rxd_data`  in  8  received byte; valid when `rxd_flag`=1
- `rxd_flag`  in  1  one-cycle pulse per received byte
- `txd_flag`  in  1  one-cycle pulse from the transmitter when a byte has finished sending
- `txd_en`  out  1  one-cycle request to the transmitter
- `txd_data`  out  8  byte to transmit; stable from `txd_en` until `txd_flag`
- `bt_w`, `bt_s`, `bt_a`, `bt_d`, `bt_st`  out  1 each  button hold outputs
- `led`  out  16  [15:11] mirror `bt_w`, `bt_s`, `bt_a`, `bt_d`, `bt_st`; [10:8] 0; [7:0] last valid command byte
- `err_cnt`  out  8  count of invalid bytes; saturates at 255

## Operation
- Decode happens only when `rxd_flag`=1. `rxd_data` is ignored otherwise.
- Command map:
  - 0x41 → W
  - 0x42 → S
  - 0x43 → A
  - 0x44 → D
  - 0x46 or 0x4E → ST
  - any other byte is invalid.
- Each button has a 24-bit down-counter.
  - A valid command loads that button's counter with `HOLD_CYCLES`.
  - A nonzero counter decrements by 1 per cycle.
  - The button output is the registered value of (counter ≠ 0).
- Retrigger: the same command arriving while its button is held reloads the full `HOLD_CYCLES`. There is no gap and no double pulse.
- Different commands are independent. Several buttons may be held at once.
- A valid byte updates `led[7:0]`. An invalid byte increments `err_cnt` (saturating) and leaves the buttons and `led[7:0]` unchanged.
- Ack byte value: the command byte itself if valid; 0x3F ('?') if invalid.
- Every decoded byte writes its ack byte into a 1-entry pending register and sets `pend_v`. A newer ack overwrites an unsent one; only the newest is kept.
- Ack FSM:
  - IDLE: if `pend_v`=1, latch `txd_data`=pending byte, clear `pend_v` → SEND.
  - SEND: `txd_en`=1 for this cycle only → WAIT.
  - WAIT: hold `txd_data`; on `txd_flag`=1 → IDLE.
  - `txd_flag` in IDLE or SEND is ignored.

## Timing
- Reset (asynchronous, `rst_n`=0):
  - all counters 0, all `bt_*` 0, `led` 0, `err_cnt` 0
  - `pend_v` 0, FSM IDLE, `txd_en` 0, `txd_data` 0
- `rxd_flag` at cycle N:
  - the button goes high at N+1 and stays high for exactly `HOLD_CYCLES` cycles, through N+`HOLD_CYCLES`.
  - `led[7:0]` and `err_cnt` update at N+1.
  - `pend_v`=1 at N+1. If the FSM is IDLE at N+1, `txd_data` is loaded at N+2 and `txd_en`=1 at N+2.
- Minimum ack turnaround: `txd_flag` at M (WAIT→IDLE at M+1). With `pend_v` set, the next `txd_en` comes at M+2.
- Simultaneous `rxd_flag` and `txd_flag` in WAIT: both take effect. The FSM returns to IDLE and the pending entry is written. No event is lost.
- `HOLD_CYCLES`=1: a single-cycle button pulse.
- Reset mid-transfer aborts WAIT and drops the pending ack. The transmitter sees no further `txd_en`.

## Test plan
- After reset, `rxd_flag` pulse with 0x41, `HOLD_CYCLES`=100 → `bt_w`=1 and `led[15]`=1 on cycles N+1..N+100, 0 at N+101; `led[7:0]`=0x41; `txd_en` pulse at N+2 with `txd_data`=0x41.
- 0x42 at N, 0x42 again at N+50 (`HOLD_CYCLES`=100) → `bt_s` is continuously high N+1..N+150 with no dropout.
- 0x4E then 0x43, 10 cycles apart → `bt_st` and `bt_a` overlap; each falls exactly 100 cycles after its own byte.
- 0x5A, repeated 300 times → `err_cnt` stops at 255; no `bt_*` asserts; every completed ack carries 0x3F.
- Three bytes 0x41, 0x42, 0x43 arrive while in WAIT, with `txd_flag` delayed 1000 cycles → after `txd_flag` only one further `txd_en`, with `txd_data`=0x43.
- `rst_n` pulsed low while `bt_d` is held and the FSM is in WAIT → all outputs 0 immediately; no `txd_en` after release until a new `rxd_flag`.
